// File: rtl/product_display_scanner.sv
// Converts an 8-bit product to BCD by shift-add-3 and time-multiplexes the
// digits onto a shared seven-segment decoder with active-low anode enables.
module product_display_scanner #(
   parameter int REFRESH_CYCLES = 50000,
   parameter bit BLANK_LEADING  = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] bin_in,
   input  logic       load,
   output logic       busy,
   output logic [3:0] digit_value,
   output logic [3:0] anode
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam int              CNT_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_CYCLES - 1);

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   logic [1:0]       r_state;
   logic [7:0]       r_shift;
   logic [11:0]      r_scratch;
   logic [2:0]       r_step;
   logic [11:0]      r_disp;
   logic [1:0]       r_idx;
   logic [CNT_W-1:0] r_cnt;

   logic [11:0]      w_adj;
   logic [19:0]      w_shifted;
   logic             w_blank;

   assign w_adj     = {add3(r_scratch[11:8]), add3(r_scratch[7:4]), add3(r_scratch[3:0])};
   assign w_shifted = {w_adj, r_shift} << 1;
   assign busy      = (r_state != S_IDLE);

   // Conversion FSM: the display register only changes when a conversion completes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_shift   <= 8'd0;
         r_scratch <= 12'd0;
         r_step    <= 3'd0;
         r_disp    <= 12'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (load) begin
                  r_shift   <= bin_in;
                  r_scratch <= 12'd0;
                  r_step    <= 3'd0;
                  r_state   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               {r_scratch, r_shift} <= w_shifted;
               r_step               <= r_step + 3'd1;
               if (r_step == 3'd7) r_state <= S_DONE;
            end
            S_DONE: begin
               r_disp  <= r_scratch;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_idx <= 2'd0;
      end else if (r_cnt == CNT_MAX) begin
         r_cnt <= '0;
         r_idx <= r_idx + 2'd1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Blanked digits still drive their nibble so the decoder input stays defined
   always_comb begin
      digit_value = 4'd0;
      w_blank     = 1'b0;
      case (r_idx)
         2'd0: digit_value = r_disp[3:0];
         2'd1: begin
            digit_value = r_disp[7:4];
            w_blank     = BLANK_LEADING && (r_disp[11:8] == 4'd0) && (r_disp[7:4] == 4'd0);
         end
         2'd2: begin
            digit_value = r_disp[11:8];
            w_blank     = BLANK_LEADING && (r_disp[11:8] == 4'd0);
         end
         default: begin
            digit_value = 4'd0;
            w_blank     = BLANK_LEADING;
         end
      endcase
   end

   assign anode = w_blank ? 4'b1111 : ~(4'b0001 << r_idx);

endmodule
